// File: rtl/vx_systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic GEMM tile.
package vx_systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Full-precision width for K_MAX products of two DATA_WIDTH operands.
  function automatic int acc_width_default(input int data_width, input int k_max);
    return 2 * data_width + $clog2(k_max);
  endfunction

endpackage

// File: rtl/vx_systolic_pe.sv
// One processing element: registered a/b/valid pass-through plus a wrapping
// signed/unsigned multiply-accumulate.
module vx_systolic_pe
  import vx_systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 22
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clr_i,
  input  logic                  is_signed_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  v_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic                  v_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic [ACC_WIDTH-1:0] a_ext, b_ext, prod, acc_q, acc_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  v_q;

  // Extending both operands to ACC_WIDTH first makes the truncated product
  // correct modulo 2^ACC_WIDTH in both signed and unsigned modes.
  always_comb begin
    a_ext = is_signed_i ? ACC_WIDTH'($signed(a_i)) : ACC_WIDTH'(a_i);
    b_ext = is_signed_i ? ACC_WIDTH'($signed(b_i)) : ACC_WIDTH'(b_i);
    prod  = a_ext * b_ext;
    acc_d = acc_q;
    if (clr_i)    acc_d = '0;
    else if (v_i) acc_d = acc_q + prod;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q   <= '0;
      b_q   <= '0;
      v_q   <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      v_q   <= v_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign v_o   = v_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/vx_systolic_tile.sv
// Output-stationary ROWS x COLS GEMM tile: skews an unskewed operand stream,
// accumulates over a runtime K, then drains results row by row.
module vx_systolic_tile
  import vx_systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int K_MAX      = 64,
  parameter int ACC_WIDTH  = acc_width_default(DATA_WIDTH, K_MAX)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   start_i,
  input  logic [$clog2(K_MAX+1)-1:0]             k_len_i,
  input  logic                                   is_signed_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]        in_a_i,
  input  logic [COLS-1:0][DATA_WIDTH-1:0]        in_b_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [(ROWS>1 ? $clog2(ROWS) : 1)-1:0] out_row_o,
  output logic [COLS-1:0][ACC_WIDTH-1:0]         out_data_o,
  output logic                                   busy_o,
  output logic                                   done_o
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS+COLS);

  state_e        state_q, state_d;
  logic [KW-1:0] klen_q, klen_d, beat_q, beat_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          sgn_q, sgn_d, done_q, done_d;
  logic          start_acc, beat_acc;

  assign in_ready_o = (state_q == ST_COMPUTE);
  assign beat_acc   = in_valid_i & in_ready_o;
  assign start_acc  = (state_q == ST_IDLE) & start_i;

  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_COMPUTE;
        klen_d  = (k_len_i == '0) ? KW'(1) : k_len_i;
        sgn_d   = is_signed_i;
        beat_d  = '0;
      end
      ST_COMPUTE: if (beat_acc) begin
        beat_d = beat_q + KW'(1);
        if (beat_q + KW'(1) == klen_q) begin
          state_d = ST_FLUSH;
          flush_d = '0;
        end
      end
      // Wait for the last beat to cross the skew to PE(ROWS-1,COLS-1).
      ST_FLUSH: begin
        if (flush_q == FW'(ROWS+COLS-2)) begin
          state_d = ST_DRAIN;
          row_d   = '0;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      ST_DRAIN: if (out_ready_i) begin
        if (row_q == RW'(ROWS-1)) begin
          state_d = ST_IDLE;
          row_d   = '0;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
    end
  end

  logic [ROWS-1:0][COLS:0][DATA_WIDTH-1:0] a_h;
  logic [ROWS-1:0][COLS:0]                 v_h;
  logic [ROWS:0][COLS-1:0][DATA_WIDTH-1:0] b_v;
  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] acc;

  // Row i sees i+1 register stages before PE(i,0); the valid flag rides along.
  for (genvar i = 0; i < ROWS; i++) begin : g_row_skew
    logic [DATA_WIDTH-1:0] a_sr [0:i];
    logic                  v_sr [0:i];
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int d = 0; d <= i; d++) begin
          a_sr[d] <= '0;
          v_sr[d] <= 1'b0;
        end
      end else begin
        a_sr[0] <= in_a_i[i];
        v_sr[0] <= beat_acc;
        for (int d = 1; d <= i; d++) begin
          a_sr[d] <= a_sr[d-1];
          v_sr[d] <= v_sr[d-1];
        end
      end
    end
    assign a_h[i][0] = a_sr[i];
    assign v_h[i][0] = v_sr[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col_skew
    logic [DATA_WIDTH-1:0] b_sr [0:j];
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int d = 0; d <= j; d++) b_sr[d] <= '0;
      end else begin
        b_sr[0] <= in_b_i[j];
        for (int d = 1; d <= j; d++) b_sr[d] <= b_sr[d-1];
      end
    end
    assign b_v[0][j] = b_sr[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe_col
      vx_systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (start_acc),
        .is_signed_i(sgn_q),
        .a_i        (a_h[i][j]),
        .b_i        (b_v[i][j]),
        .v_i        (v_h[i][j]),
        .a_o        (a_h[i][j+1]),
        .b_o        (b_v[i+1][j]),
        .v_o        (v_h[i][j+1]),
        .acc_o      (acc[i][j])
      );
    end
  end

  // Pass-through outputs off the right and bottom edges go nowhere.
  logic unused_edge;
  always_comb begin
    unused_edge = ^b_v[ROWS];
    for (int i = 0; i < ROWS; i++) unused_edge = unused_edge ^ (^a_h[i][COLS]) ^ v_h[i][COLS];
  end

  assign out_valid_o = (state_q == ST_DRAIN);
  assign out_row_o   = row_q;
  assign out_data_o  = (state_q == ST_DRAIN) ? acc[row_q] : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_vx_systolic_tile.sv
// Randomized bench for vx_systolic_tile: two geometries sharing one stimulus
// stream, results compared against a plain matrix-product model.
module tb_vx_systolic_tile;

  localparam int DW  = 8;
  localparam int KM  = 64;
  localparam int KW  = 7;
  localparam int R0  = 2, C0 = 2, A0W = 2*DW + 6;
  localparam int R1  = 3, C1 = 4, A1W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          sel = 1'b0, start = 1'b0, is_signed = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [KW-1:0] k_len = '0;
  logic [DW-1:0] cur_a [R1];
  logic [DW-1:0] cur_b [C1];

  logic [R0-1:0][DW-1:0]  a0;
  logic [C0-1:0][DW-1:0]  b0;
  logic [R1-1:0][DW-1:0]  a1;
  logic [C1-1:0][DW-1:0]  b1;
  logic                   ir0, ov0, bz0, dn0, ir1, ov1, bz1, dn1;
  logic [0:0]             orow0;
  logic [1:0]             orow1;
  logic [C0-1:0][A0W-1:0] od0;
  logic [C1-1:0][A1W-1:0] od1;

  always_comb begin
    for (int i = 0; i < R0; i++) a0[i] = cur_a[i];
    for (int j = 0; j < C0; j++) b0[j] = cur_b[j];
    for (int i = 0; i < R1; i++) a1[i] = cur_a[i];
    for (int j = 0; j < C1; j++) b1[j] = cur_b[j];
  end

  vx_systolic_tile #(.ROWS(R0), .COLS(C0), .DATA_WIDTH(DW), .K_MAX(KM)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start & ~sel), .k_len_i(k_len),
    .is_signed_i(is_signed), .in_valid_i(in_valid), .in_ready_o(ir0),
    .in_a_i(a0), .in_b_i(b0), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_row_o(orow0), .out_data_o(od0), .busy_o(bz0), .done_o(dn0));

  vx_systolic_tile #(.ROWS(R1), .COLS(C1), .DATA_WIDTH(DW), .K_MAX(KM), .ACC_WIDTH(A1W)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start & sel), .k_len_i(k_len),
    .is_signed_i(is_signed), .in_valid_i(in_valid), .in_ready_o(ir1),
    .in_a_i(a1), .in_b_i(b1), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_row_o(orow1), .out_data_o(od1), .busy_o(bz1), .done_o(dn1));

  // Outputs of whichever DUT is selected.
  logic   ir, ov, bz, dn;
  longint orow;
  longint od [C1];
  always_comb begin
    ir   = sel ? ir1 : ir0;
    ov   = sel ? ov1 : ov0;
    bz   = sel ? bz1 : bz0;
    dn   = sel ? dn1 : dn0;
    orow = sel ? longint'(orow1) : longint'(orow0);
    for (int j = 0; j < C1; j++) od[j] = sel ? longint'(od1[j]) : 0;
    for (int j = 0; j < C0; j++) if (!sel) od[j] = longint'(od0[j]);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Reference operands: A is ROWS x K, B is K x COLS.
  logic [DW-1:0] A [R1][KM];
  logic [DW-1:0] B [KM][C1];

  task automatic fill_rand();
    for (int k = 0; k < KM; k++) begin
      for (int i = 0; i < R1; i++) A[i][k] = DW'($urandom);
      for (int j = 0; j < C1; j++) B[k][j] = DW'($urandom);
    end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int k = 0; k < KM; k++) begin
      for (int i = 0; i < R1; i++) A[i][k] = av;
      for (int j = 0; j < C1; j++) B[k][j] = bv;
    end
  endtask

  function automatic longint expv(input int i, input int j, input int nb, input bit sgn, input int aw);
    longint s = 0;
    for (int k = 0; k < nb; k++) begin
      longint x = sgn ? longint'($signed(A[i][k])) : longint'(A[i][k]);
      longint y = sgn ? longint'($signed(B[k][j])) : longint'(B[k][j]);
      s += x * y;
    end
    return s & ((longint'(1) << aw) - 1);
  endfunction

  task automatic set_beat(input int k, input bit live);
    for (int i = 0; i < R1; i++) cur_a[i] = live ? A[i][k] : DW'($urandom);
    for (int j = 0; j < C1; j++) cur_b[j] = live ? B[k][j] : DW'($urandom);
  endtask

  // One full operation on DUT d; gaps toggles in_valid, stall holds out_ready
  // low for 3 cycles on row 1, noisy drives start/in_valid outside COMPUTE.
  task automatic run_op(input bit d, input int kdrv, input bit sgn,
                        input bit gaps, input bit stall, input bit noisy);
    int  nb, rr, cc, aw, k, wd, n;
    bit  tog;
    nb = (kdrv == 0) ? 1 : kdrv;
    rr = d ? R1 : R0;
    cc = d ? C1 : C0;
    aw = d ? A1W : A0W;
    @(negedge clk);
    sel = d; start = 1'b1; k_len = KW'(kdrv); is_signed = sgn; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; k_len = KW'($urandom); is_signed = ~sgn;
    chk("busy_compute", bz, 1);
    chk("in_ready", ir, 1);
    k = 0; wd = 0; tog = 1'b1;
    while (k < nb && wd < 4*nb + 10) begin
      in_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      set_beat(k, in_valid);
      if (in_valid && ir) k++;
      @(negedge clk);
      wd++;
    end
    in_valid = 1'b0;
    chk("beats_accepted", k, nb);
    chk("ready_drop", ir, 0);
    n = 1;
    while (!ov && n < 200) begin
      if (noisy) begin
        in_valid = 1'b1; start = 1'b1; set_beat(0, 1'b0);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("drain_latency", n, rr + cc);
    for (int r = 0; r < rr; r++) begin
      if (noisy) begin in_valid = 1'b1; set_beat(0, 1'b0); end
      if (stall && r == 1) begin
        for (int s = 0; s < 3; s++) begin
          out_ready = 1'b0;
          chk("stall_valid", ov, 1);
          chk("stall_row", orow, r);
          for (int j = 0; j < cc; j++) chk("stall_data", od[j], expv(r, j, nb, sgn, aw));
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk("out_valid", ov, 1);
      chk("out_row", orow, r);
      for (int j = 0; j < cc; j++) chk("out_data", od[j], expv(r, j, nb, sgn, aw));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("done_pulse", dn, 1);
    chk("idle_busy", bz, 0);
    chk("idle_valid", ov, 0);
    @(negedge clk);
    chk("done_once", dn, 0);
  endtask

  initial begin
    for (int i = 0; i < R1; i++) cur_a[i] = '0;
    for (int j = 0; j < C1; j++) cur_b[j] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", ir0, 0);
    chk("rst_valid0", ov0, 0);
    chk("rst_busy1", bz1, 0);
    chk("rst_done1", dn1, 0);
    chk("rst_data1", longint'(od1[0]), 0);
    reset = 1'b0;

    // 2x2 worked example.
    fill_const(8'd0, 8'd0);
    A[0][0] = 8'd1; A[0][1] = 8'd2; A[1][0] = 8'd3; A[1][1] = 8'd4;
    B[0][0] = 8'd5; B[0][1] = 8'd6; B[1][0] = 8'd7; B[1][1] = 8'd8;
    run_op(1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // -128 * -1 signed vs 128 * 255 unsigned.
    fill_const(8'h80, 8'hFF);
    run_op(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bubbles and backpressure against the same data without stalls.
    fill_rand();
    run_op(1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0);

    // 16-bit accumulator wraps: 2 * 255 * 255 mod 65536.
    fill_const(8'hFF, 8'hFF);
    run_op(1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of COMPUTE, then a fresh op with no residue.
    fill_rand();
    @(negedge clk);
    sel = 1'b0; start = 1'b1; k_len = KW'(4); is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin set_beat(k, 1'b1); @(negedge clk); end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_ready", ir0, 0);
    chk("midrst_busy", bz0, 0);
    chk("midrst_valid", ov0, 0);
    chk("midrst_done", dn0, 0);
    chk("midrst_row", longint'(orow0), 0);
    chk("midrst_data", longint'(od0), 0);
    reset = 1'b0;
    fill_const(8'd1, 8'd1);
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Ignored start/in_valid while busy; k_len=0 behaves as 1.
    fill_rand();
    run_op(1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b1);
    run_op(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full-depth all-ones at the default accumulator width.
    fill_const(8'hFF, 8'hFF);
    run_op(1'b0, KM, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 8; it++) begin
      fill_rand();
      run_op(1'($urandom), int'($urandom_range(1, 12)), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_systolic_tile.md
# vx_systolic_tile

Parametrised output-stationary systolic GEMM tile for the Vortex tensor path. Computes C = A×B for an R×C output tile over a runtime inner dimension K, with:
- internal input skewing and a valid/ready input stream;
- wide signed/unsigned accumulators;
- a row-by-row result drain with backpressure.

It replaces the fixed-size, free-running array: the caller streams unskewed operand slices and no longer manages alignment or accumulator clearing.

## Interface
- ROWS, 4, output-tile rows (≥1)
- COLS, 4, output-tile columns (≥1)
- DATA_WIDTH, 8, operand width
- K_MAX, 64, maximum inner dimension (≥1)
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K_MAX), accumulator/result width
- clk  in  1  clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin an operation; sampled only in IDLE
- k_len  in  $clog2(K_MAX+1)  inner dimension for this operation, 1..K_MAX; captured on start
- is_signed  in  1  operands are two's-complement; captured on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  tile accepts a beat
- in_a  in  ROWS×DATA_WIDTH  column k of A (element i → row i)
- in_b  in  COLS×DATA_WIDTH  row k of B (element j → column j)
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts a row
- out_row  out  $clog2(ROWS)  index of the presented row
- out_data  out  COLS×ACC_WIDTH  C[out_row][0..COLS-1]
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after the last row transfers

## Operation
- States: IDLE, COMPUTE, FLUSH, DRAIN.
- IDLE:
  - start=1 → COMPUTE; captures k_len and is_signed; clears all accumulators and the beat counter.
  - k_len=0 is treated as 1.
- COMPUTE:
  - in_ready=1.
  - Each in_valid&in_ready edge accepts one beat and increments beat_cnt.
  - Accepting beat number k_len → FLUSH; in_ready drops the next cycle.
  - Gaps in in_valid are allowed; a valid flag travels with the data, and PEs accumulate only on valid.
- Skew: row i of A is delayed i cycles, column j of B is delayed j cycles. Each PE registers a (passes right) and b (passes down).
- PE(i,j): acc += a*b when valid. Product is sign- or zero-extended per is_signed to ACC_WIDTH. Wraps modulo 2^ACC_WIDTH; no saturation.
- FLUSH: holds for exactly ROWS+COLS-1 cycles (counter), then → DRAIN with row index 0.
- DRAIN:
  - out_valid=1; out_data = accumulators of row out_row.
  - Each out_valid&out_ready advances out_row.
  - Transfer of row ROWS-1 → IDLE with done=1 on that next cycle.
  - out_data/out_row stay stable while out_valid&!out_ready.
- start is ignored while busy.
- in_valid outside COMPUTE is ignored.
- reset at any point, including mid-COMPUTE or mid-DRAIN:
  - next cycle: IDLE;
  - accumulators, skew/pipeline registers and valid flags zero;
  - in-flight beats discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_row=0, out_data=0, busy=0, done=0.
- The beat accepted at edge t reaches PE(i,j) and accumulates at edge t+1+i+j.
- Last beat accepted at edge t → FLUSH for cycles t+1..t+ROWS+COLS-1 → out_valid first high in cycle t+ROWS+COLS.
- With out_ready held at 1: ROWS back-to-back rows, then done in the following cycle.
- Minimum operation (no stalls): 1 (start) + k_len + (ROWS+COLS-1) + ROWS + 1 cycles, done inclusive.
- A new start is accepted in the cycle done is high (state is IDLE).

## Structure
- Package vx_systolic_pkg: state enum (IDLE, COMPUTE, FLUSH, DRAIN) and a function giving the ACC_WIDTH default.
- Sub-module vx_systolic_pe:
  - registered a/b/valid pass-through;
  - signed/unsigned multiply-accumulate;
  - synchronous clear on start or reset.
- The top holds the FSM, counters, per-row/column skew shift registers, a 2-D generate PE grid, and the drain mux.

## Test plan
- 2×2, DATA_WIDTH=8, unsigned, k_len=2; A=[[1,2],[3,4]], B=[[5,6],[7,8]] → rows [19,22] then [43,50]; first out_valid exactly ROWS+COLS cycles after the last accept.
- Signed: k_len=1, a=−128 (0x80) in all rows, b=−1 in all columns → every result +128; same bits with is_signed=0 → 128*255=32640.
- Backpressure and bubbles: in_valid toggled 1,0,1,0; out_ready low for 3 cycles during DRAIN → results identical to the no-stall run, out_data/out_row held while stalled, done exactly once.
- Wrap: ACC_WIDTH=16, k_len=2, unsigned 255*255 twice → 130050 mod 65536 = 64514.
- reset asserted mid-COMPUTE, then a fresh operation with k_len=1, a=b=1 → every result 1 (no residue); outputs at reset values the cycle after reset.
- Protocol: start while busy and in_valid during FLUSH/DRAIN are ignored; k_len=K_MAX (64) with all-ones unsigned operands → 64*255*255 = 4161600, no overflow at the default ACC_WIDTH.
